coffee_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the coffee-machine control FSM.
- Synchronises and debounces the raw level sensors (SR, SP, SN, A, VL) and the four drink-select push-buttons.
- Encodes a single accepted button press into the 2-bit selection code B1:B0 and holds it stable until the FSM has finished the drink.
- Provides a clean, glitch-free, handshaked input set for the control FSM.

---
 rtl/coffee_input_conditioner.sv | 165 ++++++++++++++++
 tb/tb_coffee_input_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_input_conditioner.sv
`timescale 1ns/1ps
// Input conditioner ahead of the coffee-machine control FSM: synchronises and debounces
// sensors and drink buttons, latches one accepted selection and handshakes it through BUSY.
module coffee_input_conditioner #(
  parameter int unsigned DEB_CYCLES     = 16'd50000,
  parameter int unsigned DEB_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 24'd5000000,
  parameter int unsigned TO_W           = 24
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SR_RAW,
  input  logic       SP_RAW,
  input  logic       SN_RAW,
  input  logic       A_RAW,
  input  logic       VL_RAW,
  input  logic [3:0] BTN_N,
  input  logic       BUSY,
  output logic       SR,
  output logic       SP,
  output logic       SN,
  output logic       A,
  output logic       VL,
  output logic       B0,
  output logic       B1,
  output logic       SEL_VALID,
  output logic       TIMEOUT
);

  localparam int unsigned NCH = 9;

  // A count that cannot be represented is never reached; the counter then parks at all-ones.
  localparam bit                DEB_REACH = (64'(DEB_CYCLES) < (64'd1 << DEB_W));
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam bit                TO_REACH  = (64'(TIMEOUT_CYCLES) < (64'd1 << TO_W));
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  // Channel map: [8]=SR [7]=SP [6]=SN [5]=A [4]=VL [3:0]=buttons (pressed = 1 after sync).
  logic [NCH-1:0]   raw_in;
  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   sync_val;
  logic [NCH-1:0]   deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [NCH];
  logic [DEB_W-1:0] deb_cnt_d [NCH];
  logic [3:0]       btn_prev_q;
  logic [3:0]       press_q;

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic             sel_q, sel_d;
  logic             timeout_q, timeout_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  assign raw_in   = {SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW, BTN_N};
  assign sync_val = {sync2_q[8:4], ~sync2_q[3:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < NCH; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_val[i] != deb_q[i]) begin
        if (DEB_REACH && (deb_cnt_q[i] == DEB_LAST)) begin
          deb_d[i] = sync_val[i];
        end else if (!(&deb_cnt_q[i])) begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      btn_prev_q <= '0;
      press_q    <= '0;
      // NOTE: this array is ordinary flops rather than a RAM, so every element takes the async reset.
      for (int i = 0; i < NCH; i++) deb_cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples its pre-edge input; blocking would merge the two sync flops.
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      btn_prev_q <= deb_q[3:0];
      press_q    <= deb_q[3:0] & ~btn_prev_q;
      for (int i = 0; i < NCH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d = 1'b0;
        // Accept only a lone press with every other button released.
        if ($onehot(press_q) && ((deb_q[3:0] & ~press_q) == 4'b0000)) begin
          code_d   = {press_q[3] | press_q[2], press_q[3] | press_q[1]};
          sel_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        sel_d = 1'b1;
        if (BUSY) begin
          state_d = S_RUN;
        end else if (TO_REACH && (to_cnt_q == TO_LAST)) begin
          sel_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!(&to_cnt_q)) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        sel_d = 1'b1;
        if (!BUSY) begin
          sel_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        sel_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      code_q    <= 2'b00;
      sel_q     <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign {SR, SP, SN, A, VL} = deb_q[8:4];
  assign B1        = code_q[1];
  assign B0        = code_q[0];
  assign SEL_VALID = sel_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_coffee_input_conditioner.sv
`timescale 1ns/1ps
// Bench for coffee_input_conditioner: directed plan steps plus random traffic, all
// compared each cycle against a sliding-window / handshake reference model.
module tb_coffee_input_conditioner;

  localparam int DEB = 4;
  localparam int TO  = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW;
  logic [3:0] BTN_N;
  logic       BUSY;
  logic       SR, SP, SN, A, VL, B0, B1, SEL_VALID, TIMEOUT;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  coffee_input_conditioner #(
    .DEB_CYCLES     (DEB),
    .DEB_W          (16),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (24)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SR_RAW    (SR_RAW),
    .SP_RAW    (SP_RAW),
    .SN_RAW    (SN_RAW),
    .A_RAW     (A_RAW),
    .VL_RAW    (VL_RAW),
    .BTN_N     (BTN_N),
    .BUSY      (BUSY),
    .SR        (SR),
    .SP        (SP),
    .SN        (SN),
    .A         (A),
    .VL        (VL),
    .B0        (B0),
    .B1        (B1),
    .SEL_VALID (SEL_VALID),
    .TIMEOUT   (TIMEOUT)
  );

  // Reference model: a debounced level follows its raw input once the raw level,
  // seen through two sync stages, has held the opposite value for DEB edges in a row.
  logic [8:0] hist [$];
  logic [8:0] m_deb, m_deb_prev;
  logic [3:0] m_press;
  int         m_phase;   // 0 idle, 1 waiting for BUSY, 2 drink running
  int         m_wait;
  logic [1:0] m_code;
  logic       m_sel, m_to;

  function automatic logic [8:0] raw_now();
    return {SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW, ~BTN_N};
  endfunction

  function automatic logic [8:0] out_vec();
    return {SR, SP, SN, A, VL, B1, B0, SEL_VALID, TIMEOUT};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_deb[8:4], m_code, m_sel, m_to};
  endfunction

  task automatic model_reset();
    hist.delete();
    // Sync flops clear to 0, which on the inverted button lines reads as "pressed".
    for (int i = 0; i < DEB + 2; i++) hist.push_back(9'h00F);
    m_deb = '0; m_deb_prev = '0; m_press = '0;
    m_phase = 0; m_wait = 0; m_code = 2'b00; m_sel = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step();
    logic [8:0] nd;
    logic [3:0] np;
    logic       same;
    hist.push_back(raw_now());
    void'(hist.pop_front());
    for (int ch = 0; ch < 9; ch++) begin
      same = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i][ch] == m_deb[ch]) same = 1'b0;
      nd[ch] = same ? ~m_deb[ch] : m_deb[ch];
    end
    np   = m_deb[3:0] & ~m_deb_prev[3:0];
    m_to = 1'b0;
    case (m_phase)
      0: if ($countones(m_press) == 1 && (m_deb[3:0] & ~m_press) == 4'b0000) begin
           for (int k = 0; k < 4; k++) if (m_press[k]) m_code = 2'(k);
           m_sel = 1'b1; m_phase = 1; m_wait = 0;
         end
      1: if (BUSY) m_phase = 2;
         else if (m_wait == TO - 1) begin m_phase = 0; m_sel = 1'b0; m_to = 1'b1; end
         else m_wait++;
      default: if (!BUSY) begin m_phase = 0; m_sel = 1'b0; end
    endcase
    m_press    = np;
    m_deb_prev = m_deb;
    m_deb      = nd;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_step(); else model_reset();
    @(negedge CLK);
    check("model", out_vec(), exp_vec());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s;
    int         idx;

    {SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW} = 5'h1F;
    BTN_N = 4'hF;
    BUSY  = 1'b0;
    #1 RST_N = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_outs", out_vec(), 9'h000);

    // Power-up: sensors appear 2 + DEB edges after reset release.
    RST_N = 1'b1;
    repeat (5) tick();
    check("sens_pre", {4'd0, SR, SP, SN, A, VL}, 9'h000);
    tick();
    check("sens_rise", {4'd0, SR, SP, SN, A, VL}, 9'h01F);
    check("sel_idle", {8'd0, SEL_VALID}, 9'd0);

    // Bounce on SP: 2-cycle levels never reach the output.
    for (int p = 0; p < 4; p++) begin
      SP_RAW = p[0];
      repeat (2) begin tick(); check("sp_bounce", {8'd0, SP}, 9'd1); end
    end
    SP_RAW = 1'b0;
    repeat (5) tick();
    check("sp_hold", {8'd0, SP}, 9'd1);
    tick();
    check("sp_fall", {8'd0, SP}, 9'd0);
    SP_RAW = 1'b1;
    repeat (6) tick();

    // Clean press of button 2, a second press while armed, then a BUSY handshake.
    BTN_N = 4'b1011;
    tick(); tick();
    BTN_N = 4'b1001;
    repeat (5) tick();
    check("sel_pre", {8'd0, SEL_VALID}, 9'd0);
    tick();
    check("sel_arm", {6'd0, B1, B0, SEL_VALID}, 9'b101);
    tick(); tick();
    check("armed_ignore", {6'd0, B1, B0, SEL_VALID}, 9'b101);
    BUSY  = 1'b1;
    BTN_N = 4'hF;
    repeat (10) tick();
    check("run_hold", {6'd0, B1, B0, SEL_VALID}, 9'b101);
    BUSY = 1'b0;
    tick();
    check("busy_fall", {6'd0, B1, B0, SEL_VALID}, 9'b100);
    repeat (8) tick();

    // Two buttons together are rejected.
    BTN_N = 4'b0110;
    repeat (10) tick();
    check("simul", {6'd0, B1, B0, SEL_VALID}, 9'b100);
    BTN_N = 4'hF;
    repeat (10) tick();
    check("simul_rel", {6'd0, B1, B0, SEL_VALID}, 9'b100);

    // Timeout: button 3 armed, BUSY never comes.
    BTN_N = 4'b0111;
    repeat (8) tick();
    check("to_arm", {5'd0, B1, B0, SEL_VALID, TIMEOUT}, 9'b1110);
    repeat (7) tick();
    check("to_wait", {5'd0, B1, B0, SEL_VALID, TIMEOUT}, 9'b1110);
    tick();
    check("to_pulse", {5'd0, B1, B0, SEL_VALID, TIMEOUT}, 9'b1101);
    tick();
    check("to_end", {5'd0, B1, B0, SEL_VALID, TIMEOUT}, 9'b1100);
    BTN_N = 4'hF;
    repeat (8) tick();

    // Reset in the middle of a drink clears everything at once.
    BTN_N = 4'b1110;
    repeat (8) tick();
    BUSY  = 1'b1;
    BTN_N = 4'hF;
    repeat (3) tick();
    check("run_b0", {6'd0, B1, B0, SEL_VALID}, 9'b001);
    #1 RST_N = 1'b0;
    #1 model_reset();
    check("rst_async", out_vec(), 9'h000);
    tick();
    RST_N = 1'b1;
    repeat (6) tick();
    check("rst_recover", {4'd0, SR, SP, SN, A, VL}, 9'h01F);
    check("busy_idle", {8'd0, SEL_VALID}, 9'd0);
    BUSY = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        s   = {SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW};
        idx = int'($urandom_range(0, 4));
        s[idx] = ~s[idx];
        {SR_RAW, SP_RAW, SN_RAW, A_RAW, VL_RAW} = s;
      end
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       BTN_N = 4'hF;
          1:       BTN_N = ~(4'b0001 << $urandom_range(0, 3));
          2:       BTN_N = 4'($urandom);
          default: BTN_N = 4'hF;
        endcase
      end
      if ($urandom_range(0, 9) == 0) BUSY = ~BUSY;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
